// File: rtl/booth_div_if.sv
// Start/valid handshake and operand/result bus for the sequential signed divider.
interface booth_div_if #(
  parameter int N = 4
);
  logic             start;
  logic [2*N-1:0]   X;
  logic [N-1:0]     Y;
  logic             busy;
  logic             valid;
  logic [N-1:0]     Q;
  logic [N-1:0]     R;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, X, Y,
    input  busy, valid, Q, R, dbz, ovf
  );

  modport slave (
    input  start, X, Y,
    output busy, valid, Q, R, dbz, ovf
  );
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, truncating.
// Restoring division on magnitudes, one quotient bit per clock, with
// divide-by-zero and quotient-overflow detection.
module booth_div #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  booth_div_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [N:0]      p_q;
  logic [N-1:0]    s_q;
  logic [N-1:0]    ay_q;
  logic            sgnq_q;
  logic            sgnr_q;
  logic            err_dbz_q;
  logic            err_ovf_q;
  logic [N-1:0]    q_q;
  logic [N-1:0]    r_q;
  logic            valid_q;
  logic            dbz_q;
  logic            ovf_q;

  logic [2*N-1:0]  ax_d;
  logic [N-1:0]    ay_d;
  logic            pre_dbz_d;
  logic            pre_ovf_d;
  logic [N+1:0]    trial_d;
  logic            trial_ok_d;
  logic [N:0]      p_d;
  logic [N-1:0]    s_d;
  logic            range_ovf_d;
  logic [N-1:0]    qfix_d;
  logic [N-1:0]    rfix_d;

  // Operand magnitudes, precheck, one restoring step and final sign fix-up.
  always_comb begin
    ax_d      = bus.X[2*N-1] ? -bus.X : bus.X;
    ay_d      = bus.Y[N-1]   ? -bus.Y : bus.Y;
    pre_dbz_d = (bus.Y == '0);
    pre_ovf_d = !pre_dbz_d && (ax_d[2*N-1:N] >= ay_d);

    // Shift {P,S} left by one and try subtracting |Y|; borrow means restore.
    trial_d    = {p_q, s_q[N-1]} - {2'b00, ay_q};
    trial_ok_d = !trial_d[N+1];
    p_d        = trial_ok_d ? trial_d[N:0] : {p_q[N-1:0], s_q[N-1]};
    s_d        = {s_q[N-2:0], trial_ok_d};

    // Negative quotients may reach 2^(N-1); positive ones only 2^(N-1)-1.
    range_ovf_d = sgnq_q ? (s_q[N-1] && (s_q[N-2:0] != '0)) : s_q[N-1];
    qfix_d      = sgnq_q ? -s_q : s_q;
    rfix_d      = sgnr_q ? -p_q[N-1:0] : p_q[N-1:0];
  end

  // Control FSM with registered datapath and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      p_q       <= '0;
      s_q       <= '0;
      ay_q      <= '0;
      sgnq_q    <= 1'b0;
      sgnr_q    <= 1'b0;
      err_dbz_q <= 1'b0;
      err_ovf_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            p_q       <= {1'b0, ax_d[2*N-1:N]};
            s_q       <= ax_d[N-1:0];
            ay_q      <= ay_d;
            sgnq_q    <= bus.X[2*N-1] ^ bus.Y[N-1];
            sgnr_q    <= bus.X[2*N-1];
            err_dbz_q <= pre_dbz_d;
            err_ovf_q <= pre_ovf_d;
            count_q   <= '0;
            state_q   <= (pre_dbz_d || pre_ovf_d) ? FIX : RUN;
          end
        end
        RUN: begin
          p_q     <= p_d;
          s_q     <= s_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) state_q <= FIX;
        end
        FIX: begin
          valid_q <= 1'b1;
          state_q <= IDLE;
          if (err_dbz_q) begin
            q_q <= '0; r_q <= '0; dbz_q <= 1'b1; ovf_q <= 1'b0;
          end else if (err_ovf_q || range_ovf_d) begin
            q_q <= '0; r_q <= '0; dbz_q <= 1'b0; ovf_q <= 1'b1;
          end else begin
            q_q <= qfix_d; r_q <= rfix_d; dbz_q <= 1'b0; ovf_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.valid = valid_q;
  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.dbz   = dbz_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_booth_div.sv
// Directed and random checks of booth_div against a plain-integer
// truncating-division model.
module tb_booth_div;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_div_if #(.N(N)) bus ();
  booth_div #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: truncating division, flags and accept-to-valid edge count.
  function automatic void model(input int x, input int y, output int q, output int r,
                                output bit dz, output bit ov, output int lat);
    int qt;
    dz = (y == 0); ov = 1'b0; q = 0; r = 0; lat = 1;
    if (!dz) begin
      lat = ((iabs(x) / iabs(y)) >= (1 << N)) ? 1 : N + 1;
      qt  = x / y;
      if (qt > (1 << (N-1)) - 1 || qt < -(1 << (N-1))) ov = 1'b1;
      else begin q = qt; r = x % y; end
    end
  endfunction

  // Cycle-level expectation: what the outputs must show after each edge.
  bit m_busy = 0, m_valid = 0;
  int m_left = 0;
  int eq = 0, er = 0, ex = 0, ey = 0;
  bit edz = 0, eov = 0;
  int pq, pr, px, py, plat;
  bit pdz, pov;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_left = 0; m_valid = 0;
      eq = 0; er = 0; edz = 0; eov = 0;
    end else begin
      m_valid = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_valid = 1;
          eq = pq; er = pr; edz = pdz; eov = pov; ex = px; ey = py;
        end
      end else if (bus.start) begin
        px = int'($signed(bus.X));
        py = int'($signed(bus.Y));
        model(px, py, pq, pr, pdz, pov, plat);
        m_left = plat;
        m_busy = 1;
      end
    end
  end

  // Every-cycle comparison, plus result invariants on each good result.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("valid", int'(bus.valid), int'(m_valid));
      chk("Q", int'($signed(bus.Q)), eq);
      chk("R", int'($signed(bus.R)), er);
      chk("dbz", int'(bus.dbz), int'(edz));
      chk("ovf", int'(bus.ovf), int'(eov));
      if (bus.valid && !bus.dbz && !bus.ovf) begin
        chk("inv_xqyr", int'($signed(bus.Q)) * ey + int'($signed(bus.R)), ex);
        chk("inv_rmag", int'(iabs(int'($signed(bus.R))) < iabs(ey)), 1);
        chk("inv_rsign", int'(bus.R == '0 || (bus.R[N-1] == (ex < 0))), 1);
      end
    end
  end

  task automatic issue(input int x, input int y);
    bus.X = W'(x);
    bus.Y = N'(y);
    bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
  endtask

  // Wait (bounded) for valid; check latency in negedges and literal results.
  task automatic await(input string tag, input int lat, input int q, input int r,
                       input bit dz, input bit ov, output int nbusy);
    int k;
    bit got;
    got = 0; nbusy = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.valid) begin got = 1; break; end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_lat"}, k, lat);
      chk({tag, "_Q"}, int'($signed(bus.Q)), q);
      chk({tag, "_R"}, int'($signed(bus.R)), r);
      chk({tag, "_dbz"}, int'(bus.dbz), int'(dz));
      chk({tag, "_ovf"}, int'(bus.ovf), int'(ov));
    end
  endtask

  typedef struct { int x; int y; int q; int r; bit dz; bit ov; int lat; } vec_t;
  vec_t vecs[$];

  initial begin
    int nb, q, r, lat, x, y, v;
    bit dz, ov;

    // Pin the model with hand-computed values.
    model(45, 7, q, r, dz, ov, lat);
    chk("model_45_7_q", q, 6); chk("model_45_7_r", r, 3); chk("model_45_7_lat", lat, 5);
    model(-45, -7, q, r, dz, ov, lat);
    chk("model_n45_n7_q", q, 6); chk("model_n45_n7_r", r, -3);
    model(-64, -8, q, r, dz, ov, lat);
    chk("model_n64_n8_ovf", int'(ov), 1); chk("model_n64_n8_lat", lat, 5);
    model(-128, -8, q, r, dz, ov, lat);
    chk("model_n128_n8_lat", lat, 1);
    model(17, 0, q, r, dz, ov, lat);
    chk("model_dbz", int'(dz), 1);

    bus.start = 1'b0; bus.X = '0; bus.Y = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_Q", int'(bus.Q), 0);
    chk("rst_R", int'(bus.R), 0);

    // First op: latency 6 negedges, busy for 5 of them.
    issue(45, 7);
    await("d45_7", 6, 6, 3, 0, 0, nb);
    chk("d45_7_busy_cycles", nb, 5);

    vecs = '{
      '{x: -45, y:  7, q: -6, r: -3, dz: 0, ov: 0, lat: 6},
      '{x:  45, y: -7, q: -6, r:  3, dz: 0, ov: 0, lat: 6},
      '{x: -45, y: -7, q:  6, r: -3, dz: 0, ov: 0, lat: 6},
      '{x:  64, y: -8, q: -8, r:  0, dz: 0, ov: 0, lat: 6},
      '{x: -64, y: -8, q:  0, r:  0, dz: 0, ov: 1, lat: 6},
      '{x: 100, y:  7, q:  0, r:  0, dz: 0, ov: 1, lat: 6},
      '{x: -128, y: -8, q: 0, r:  0, dz: 0, ov: 1, lat: 2},
      '{x: 127, y:  1, q:  0, r:  0, dz: 0, ov: 1, lat: 2},
      '{x:  -8, y:  1, q: -8, r:  0, dz: 0, ov: 0, lat: 6},
      '{x:  17, y:  0, q:  0, r:  0, dz: 1, ov: 0, lat: 2}
    };
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].x, vecs[i].y);
      await($sformatf("v%0d", i), vecs[i].lat, vecs[i].q, vecs[i].r,
            vecs[i].dz, vecs[i].ov, nb);
    end

    // start during RUN is ignored; result belongs to the first operands.
    @(negedge clk);
    issue(45, 7);
    @(posedge clk);
    #2 begin bus.X = W'(-20); bus.Y = N'(3); bus.start = 1'b1; end
    @(posedge clk);
    #2 bus.start = 1'b0;
    await("midrun", 4, 6, 3, 0, 0, nb);

    // Back-to-back: new start on the valid cycle, no gap.
    @(negedge clk);
    issue(45, -7);
    await("b2b_a", 6, -6, 3, 0, 0, nb);
    issue(-20, 3);
    await("b2b_b", 6, -6, -2, 0, 0, nb);

    // Reset at the edge where count==2: no valid, outputs cleared.
    @(negedge clk);
    issue(45, 7);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("rstmid_valid", int'(bus.valid), 0);
      chk("rstmid_busy", int'(bus.busy), 0);
    end
    chk("rstmid_Q", int'(bus.Q), 0);
    chk("rstmid_R", int'(bus.R), 0);
    chk("rstmid_ovf", int'(bus.ovf), 0);
    issue(9, 2);
    await("after_rst", 6, 4, 1, 0, 0, nb);

    // Random pairs, half biased toward in-range quotients.
    for (int i = 0; i < 10000; i++) begin
      y = int'($signed(N'($urandom_range(0, (1 << N) - 1))));
      if ($urandom_range(0, 1) == 1) begin
        x = int'($signed(W'($urandom_range(0, (1 << W) - 1))));
      end else begin
        v = $urandom_range(0, 8 * iabs(y) + 7);
        x = ($urandom_range(0, 1) == 1) ? -v : v;
      end
      model(x, y, q, r, dz, ov, lat);
      issue(x, y);
      await("rand", lat + 1, q, r, dz, ov, nb);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
